// File: rtl/regfile_scoreboard.sv
// Register-file client with per-register pending-write counters.
// Stalls issue on RAW and counter-full hazards and bypasses same-cycle writeback data.
module regfile_scoreboard #(
  parameter int PEND_MAX = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_sel,
  input  logic [31:0] wb_dat,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [4:0]  rf_rsel1,
  output logic [4:0]  rf_rsel2,
  input  logic [31:0] rf_rdat1,
  input  logic [31:0] rf_rdat2,
  output logic        busy,
  output logic [6:0]  outstanding,
  output logic        wb_err
);

  localparam logic [1:0] PMAX = 2'(PEND_MAX);

  logic [1:0] cnt     [32];
  logic [1:0] cnt_nxt [32];
  logic [6:0] outstanding_q;
  logic [6:0] outstanding_nxt;
  logic       busy_q;
  logic       wb_err_q;

  logic       wb_live;
  logic       rs_hit;
  logic       rt_hit;
  logic       rd_hit;
  logic       rs_pend;
  logic       rt_pend;
  logic       rd_full;
  logic       accept;
  logic       inc_any;
  logic       dec_any;
  logic       err_evt;
  logic [1:0] cnt_rs;
  logic [1:0] cnt_rt;
  logic [1:0] cnt_rd;
  logic [1:0] cnt_wb;

  assign wb_live = wb_valid && (wb_sel != 5'd0);

  assign rf_WEN   = wb_live;
  assign rf_wsel  = wb_sel;
  assign rf_wdat  = wb_dat;
  assign rf_rsel1 = issue_rs;
  assign rf_rsel2 = issue_rt;

  assign cnt_rs = cnt[issue_rs];
  assign cnt_rt = cnt[issue_rt];
  assign cnt_rd = cnt[issue_rd];
  assign cnt_wb = cnt[wb_sel];

  // wb_live already excludes r0, so every hit below is on a real register
  assign rs_hit = wb_live && (wb_sel == issue_rs);
  assign rt_hit = wb_live && (wb_sel == issue_rt);
  assign rd_hit = wb_live && (wb_sel == issue_rd);

  // A source is still pending unless the last outstanding write retires this cycle
  assign rs_pend = (issue_rs != 5'd0) && (cnt_rs != 2'd0) && !(rs_hit && (cnt_rs == 2'd1));
  assign rt_pend = (issue_rt != 5'd0) && (cnt_rt != 2'd0) && !(rt_hit && (cnt_rt == 2'd1));
  assign rd_full = issue_wr && (issue_rd != 5'd0) && (cnt_rd == PMAX) && !rd_hit;

  assign issue_ready = !(rs_pend || rt_pend || rd_full);

  assign op1 = rs_hit ? wb_dat : rf_rdat1;
  assign op2 = rt_hit ? wb_dat : rf_rdat2;

  assign accept  = issue_valid && issue_ready;
  assign inc_any = accept && issue_wr && (issue_rd != 5'd0);
  assign dec_any = wb_live && (cnt_wb != 2'd0);
  assign err_evt = wb_live && (cnt_wb == 2'd0);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    for (int r = 1; r < 32; r++) begin
      if (inc_any && (issue_rd == 5'(r)) && !(dec_any && (wb_sel == 5'(r)))) begin
        cnt_nxt[r] = cnt[r] + 2'd1;
      end else if (dec_any && (wb_sel == 5'(r)) && !(inc_any && (issue_rd == 5'(r)))) begin
        cnt_nxt[r] = cnt[r] - 2'd1;
      end
    end
    cnt_nxt[0] = 2'd0;
  end

  always_comb begin
    outstanding_nxt = outstanding_q;
    if (inc_any && !dec_any) begin
      outstanding_nxt = outstanding_q + 7'd1;
    end else if (dec_any && !inc_any) begin
      outstanding_nxt = outstanding_q - 7'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= 2'd0;
      end
      outstanding_q <= 7'd0;
      busy_q        <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      outstanding_q <= outstanding_nxt;
      busy_q        <= (outstanding_nxt != 7'd0);
      if (err_evt) begin
        wb_err_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: behavioural pending-count model plus literal checkpoints.
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_wr;
  logic        issue_ready;
  logic [31:0] op1, op2;
  logic        wb_valid;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rf_rsel1, rf_rsel2;
  logic [31:0] rf_rdat1, rf_rdat2;
  logic        busy;
  logic [6:0]  outstanding;
  logic        wb_err;

  int checks = 0;
  int passes = 0;

  int m_cnt [32];
  int m_err;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rfpat(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    return {16'hA5A5, 11'd0, r};
  endfunction

  assign rf_rdat1 = rfpat(rf_rsel1);
  assign rf_rdat2 = rfpat(rf_rsel2);

  regfile_scoreboard #(.PEND_MAX(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .op1(op1), .op2(op2),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
    .busy(busy), .outstanding(outstanding), .wb_err(wb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---- model ----
  function automatic bit m_hit(input int r);
    return wb_valid && (int'(wb_sel) == r) && (r != 0);
  endfunction

  function automatic int m_eff(input int r);
    if (r == 0) return 0;
    if (m_hit(r) && m_cnt[r] > 0) return m_cnt[r] - 1;
    return m_cnt[r];
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = (m_eff(int'(issue_rs)) != 0) || (m_eff(int'(issue_rt)) != 0) ||
         (issue_wr && issue_rd != 0 && m_cnt[issue_rd] == 3 && !m_hit(int'(issue_rd)));
    return !hz;
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
    end else begin
      bit acc;
      acc = issue_valid && m_ready();
      if (wb_valid && wb_sel != 0) begin
        if (m_cnt[wb_sel] == 0) m_err = 1;
        else m_cnt[wb_sel] = m_cnt[wb_sel] - 1;
      end
      if (acc && issue_wr && issue_rd != 0) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
    end
  end

  // ---- per-cycle comparison against the model ----
  always @(negedge CLK) begin
    chk("ready", {31'd0, issue_ready}, {31'd0, m_ready()});
    chk("op1", op1, m_hit(int'(issue_rs)) ? wb_dat : rfpat(issue_rs));
    chk("op2", op2, m_hit(int'(issue_rt)) ? wb_dat : rfpat(issue_rt));
    chk("rf_WEN", {31'd0, rf_WEN}, {31'd0, wb_valid && wb_sel != 0});
    chk("rf_wsel", {27'd0, rf_wsel}, {27'd0, wb_sel});
    chk("rf_wdat", rf_wdat, wb_dat);
    chk("rf_rsel", {22'd0, rf_rsel1, rf_rsel2}, {22'd0, issue_rs, issue_rt});
    chk("outstanding", {25'd0, outstanding}, 32'(m_total()));
    chk("busy", {31'd0, busy}, {31'd0, m_total() != 0});
    chk("wb_err", {31'd0, wb_err}, 32'(m_err));
  end

  task automatic set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic wr,
                     input logic wv, input logic [4:0] ws, input logic [31:0] wd);
    issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wr = wr;
    wb_valid = wv; wb_sel = ws; wb_dat = wd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic wr;
    logic wv; logic [4:0] ws; logic [31:0] wd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    nRST = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_outstanding", {25'd0, outstanding}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();

    // first write to r3, then RAW stall released by same-cycle writeback
    set(1, 1, 2, 3, 1, 0, 0, 0);
    #1 chk("iss1_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("iss1_out", {25'd0, outstanding}, 32'd1);
    chk("iss1_busy", {31'd0, busy}, 32'd1);
    set(1, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall", {31'd0, issue_ready}, 32'd0);
    set(1, 3, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    #1;
    chk("byp_ready", {31'd0, issue_ready}, 32'd1);
    chk("byp_op1", op1, 32'hDEADBEEF);
    chk("byp_wen", {31'd0, rf_WEN}, 32'd1);
    chk("byp_wsel", {27'd0, rf_wsel}, 32'd3);
    tick();
    chk("byp_busy", {31'd0, busy}, 32'd0);
    chk("byp_out", {25'd0, outstanding}, 32'd0);
    set(1, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("direct_op1", op1, 32'hA5A50003);

    // saturate r5
    set(1, 0, 0, 5, 1, 0, 0, 0);
    repeat (3) tick();
    chk("sat_out", {25'd0, outstanding}, 32'd3);
    #1 chk("sat_stall", {31'd0, issue_ready}, 32'd0);
    set(1, 0, 0, 5, 1, 1, 5, 32'h55);
    #1 chk("sat_wb_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("sat_hold", {25'd0, outstanding}, 32'd3);
    set(1, 5, 0, 0, 0, 0, 0, 0);
    #1 chk("sat_reader", {31'd0, issue_ready}, 32'd0);

    // register 0 handling
    set(1, 0, 0, 0, 1, 1, 0, 32'h1234);
    #1;
    chk("r0_wen", {31'd0, rf_WEN}, 32'd0);
    chk("r0_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("r0_out", {25'd0, outstanding}, 32'd3);
    chk("r0_err", {31'd0, wb_err}, 32'd0);

    // stray writeback to r7
    set(0, 0, 0, 0, 0, 1, 7, 32'h77);
    #1 chk("r7_wen", {31'd0, rf_WEN}, 32'd1);
    tick();
    chk("r7_err", {31'd0, wb_err}, 32'd1);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("r7_sticky", {31'd0, wb_err}, 32'd1);

    // async reset with four writes in flight
    set(1, 0, 0, 9, 1, 0, 0, 0);
    tick();
    chk("pre_rst_out", {25'd0, outstanding}, 32'd4);
    set(1, 5, 0, 0, 0, 0, 0, 0);
    #1 nRST = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out", {25'd0, outstanding}, 32'd0);
    chk("arst_err", {31'd0, wb_err}, 32'd0);
    chk("arst_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    nRST = 1'b1;
    set(0, 0, 0, 0, 0, 1, 5, 32'h5);
    tick();
    chk("post_rst_err", {31'd0, wb_err}, 32'd1);

    // mixed directed sequence, checked by the model each cycle
    tbl[0] = '{1, 0, 0, 10, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 11, 1, 0, 0, 0};
    tbl[2] = '{1, 10, 11, 12, 1, 0, 0, 0};
    tbl[3] = '{1, 10, 11, 12, 1, 1, 10, 32'hA0};
    tbl[4] = '{1, 10, 11, 12, 1, 1, 11, 32'hB1};
    tbl[5] = '{1, 12, 12, 12, 1, 0, 0, 0};
    tbl[6] = '{1, 12, 0, 0, 0, 1, 12, 32'hC2};
    tbl[7] = '{0, 0, 0, 0, 0, 1, 12, 32'hC3};
    foreach (tbl[i]) begin
      set(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].wr, tbl[i].wv, tbl[i].ws, tbl[i].wd);
      tick();
    end
    set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mix_out", {25'd0, outstanding}, 32'd0);
    chk("mix_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Client-side controller for the 32×32 register file: it drives the register file's read selects and write port, and tracks in-flight destination writes with per-register pending counters. It stalls issue on read-after-write and counter-overflow hazards, and bypasses same-cycle writeback data onto the operand outputs. It sits between decode/issue and the register file, and is the write/read initiator on the register file interface.

## Interface
- PEND_MAX, 3: maximum outstanding writes per register (counter saturation point); counter width 2 bits.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue request present.
- issue_rs  in  5  source register 1.
- issue_rt  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_wr  in  1  instruction writes issue_rd.
- issue_ready  out  1  request may be accepted this cycle (combinational).
- op1  out  32  operand for issue_rs (bypassed).
- op2  out  32  operand for issue_rt (bypassed).
- wb_valid  in  1  writeback completion this cycle.
- wb_sel  in  5  writeback destination register.
- wb_dat  in  32  writeback data.
- rf_WEN  out  1  register file write enable.
- rf_wsel  out  5  register file write select.
- rf_wdat  out  32  register file write data.
- rf_rsel1  out  5  register file read select 1 (= issue_rs).
- rf_rsel2  out  5  register file read select 2 (= issue_rt).
- rf_rdat1  in  32  register file read data 1.
- rf_rdat2  in  32  register file read data 2.
- busy  out  1  any pending counter non-zero (registered).
- outstanding  out  7  total in-flight writes, 0..93 (registered).
- wb_err  out  1  sticky: writeback to a register with zero pending count.

## Operation
- State: cnt[1..31], 2 bits each; cnt[0] does not exist and always reads 0; outstanding counter; wb_err flag.
- Write port: rf_WEN = wb_valid && wb_sel != 0; rf_wsel = wb_sel; rf_wdat = wb_dat. Writes to register 0 are never driven.
- Define wb_hit(r) = wb_valid && wb_sel == r && r != 0.
- Define eff(r) = cnt[r] − 1 if wb_hit(r) and cnt[r] != 0, else cnt[r].
- Hazard when any of the following holds:
  - issue_rs != 0 && eff(rs) != 0.
  - issue_rt != 0 && eff(rt) != 0.
  - issue_wr && issue_rd != 0 && cnt[rd] == PEND_MAX && !wb_hit(rd).
- issue_ready = !hazard. It is independent of issue_valid.
- Bypass:
  - op1 = wb_dat if wb_hit(issue_rs), else rf_rdat1.
  - op2 = wb_dat if wb_hit(issue_rt), else rf_rdat2.
  - Register 0 reads rf data, which is 0.
- Accept = issue_valid && issue_ready.
  - inc(r) = Accept && issue_wr && issue_rd == r && r != 0.
  - dec(r) = wb_hit(r) && cnt[r] != 0.
- Per-register update: inc only → +1; dec only → −1; both → unchanged; neither → unchanged.
- outstanding changes by (+1 if any inc) − (1 if any dec).
- busy reflects registered state, i.e. outstanding != 0 after the edge.
- wb_err sets when wb_hit(r) && cnt[r] == 0. No counter changes for that event, but the rf write still occurs. wb_err clears only on reset.
- Counters never wrap: the hazard rule prevents increment at PEND_MAX, and decrement at 0 is suppressed.

## Timing
- Reset (nRST low, asynchronous): all cnt = 0, outstanding = 0, busy = 0, wb_err = 0.
  - Combinational outputs during reset: issue_ready = 1, and the rf_* outputs follow their inputs.
  - Reset mid-operation discards all pending state. Any later writeback then raises wb_err.
- issue_ready, op1/op2 and rf_* are same-cycle combinational. Counter, busy and outstanding effects appear after the next rising edge.
- Issue-to-hazard latency: an instruction accepted in cycle N writing rX makes a cycle N+1 reader of rX stall.
- Writeback in cycle M that brings cnt to 0 releases a stalled reader in cycle M itself, via bypass. From M+1 the reader reads the register file directly.
- Simultaneous accept writing rX and writeback of rX with cnt[rX] == PEND_MAX: accept is allowed and the count stays at PEND_MAX.

## Test plan
- Reset, then issue rs=1, rt=2, wr rd=3 → issue_ready=1; after the edge cnt[3]=1, busy=1, outstanding=1.
- Next cycle issue rs=3 → issue_ready=0. Then wb_valid, wb_sel=3, wb_dat=0xDEADBEEF in the same cycle → issue_ready=1, op1=0xDEADBEEF, rf_WEN=1, rf_wsel=3; after the edge cnt[3]=0, busy=0.
- Three accepted writes to r5 → cnt=3; a fourth write to r5 stalls. The fourth write with a simultaneous wb_sel=5 → accepted, cnt stays 3, outstanding stays 3.
- Writes and reads of r0: issue wr rd=0 leaves cnt unchanged; wb_sel=0 gives rf_WEN=0 and no wb_err; rs=0 never stalls.
- Writeback to r7 with cnt[7]=0 → wb_err=1 after the edge and sticky; rf_WEN=1.
- Assert nRST low mid-stream with outstanding=4 → immediately busy=0, outstanding=0, wb_err=0 and issue_ready=1 with no clock edge.
